// File: rtl/placement_cost_eval_if.sv
`default_nettype none
// ============================================================================
// Module      : placement_cost_eval_if
// Description : Stream bundle feeding placement_cost_eval. Carries the
//               position stream (node index + X/Y coordinate) and the edge
//               stream (source, sink, last marker), each with valid/ready.
//               master : producer side (drives valid/payload, reads ready)
//               slave  : consumer side (reads valid/payload, drives ready)
// Revision    : 1.0  initial release
// ============================================================================
interface placement_cost_eval_if #(
   parameter int CW = 32,
   parameter int IW = 8
) ();

   // position stream
   logic          pos_valid;
   logic          pos_ready;
   logic [IW-1:0] pos_node;
   logic [CW-1:0] pos_x;
   logic [CW-1:0] pos_y;

   // edge stream
   logic          edge_valid;
   logic          edge_ready;
   logic [IW-1:0] edge_a;
   logic [IW-1:0] edge_b;
   logic          edge_last;

   modport master (
      output pos_valid, pos_node, pos_x, pos_y,
      input  pos_ready,
      output edge_valid, edge_a, edge_b, edge_last,
      input  edge_ready
   );

   modport slave (
      input  pos_valid, pos_node, pos_x, pos_y,
      output pos_ready,
      input  edge_valid, edge_a, edge_b, edge_last,
      output edge_ready
   );

endinterface
`default_nettype wire

// File: rtl/placement_cost_eval.sv
`default_nettype none
// ============================================================================
// Module      : placement_cost_eval
// Description : Validates a grid placement and totals its wire cost. Node
//               positions arrive first (exactly N_NODE beats), then the edge
//               list; each edge costs max(|dx|+|dy|-1, 0).
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous reset, active low
//               start      - one-cycle pulse, begins a run from IDLE/DONE
//               bus        - slave side of placement_cost_eval_if
//                            (position and edge valid/ready streams)
//               busy       - high while loading or evaluating
//               done       - one-cycle pulse on entering DONE
//               sum        - accumulated wire cost (wraps modulo 2^CW)
//               max_len    - longest error-free edge length
//               edge_count - number of edges accepted
//               err_*      - sticky error flags (unplaced/range/overlap/index)
// Options     : `define PLACEMENT_COST_MAX_LEN_EN builds the max_len tracker;
//               without it max_len is tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
module placement_cost_eval #(
   parameter int N      = 4,
   parameter int N_NODE = 14,
   parameter int CW     = 32,
   parameter int IW     = 8
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic          start,
   placement_cost_eval_if.slave bus,
   output logic               busy,
   output logic               done,
   output logic [CW-1:0]      sum,
   output logic [CW-1:0]      max_len,
   output logic [CW-1:0]      edge_count,
   output logic               err_unplaced,
   output logic               err_range,
   output logic               err_overlap,
   output logic               err_index
);

   localparam int            AW         = (N_NODE > 1) ? $clog2(N_NODE) : 1;
   localparam int            CNT_W      = $clog2(N_NODE + 1);
   localparam int            CELL_W     = (N * N > 1) ? $clog2(N * N) : 1;
   localparam logic [CW-1:0] c_UNPLACED = {CW{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_EVAL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic [CW-1:0]        r_mem_x [0:N_NODE-1];
   logic [CW-1:0]        r_mem_y [0:N_NODE-1];
   logic [N*N-1:0]       r_occ;
   logic [CNT_W-1:0]     r_pos_cnt;
   logic [CW-1:0]        r_sum;
   logic [CW-1:0]        r_edge_count;
   logic                 r_done;
   logic                 r_err_unplaced;
   logic                 r_err_range;
   logic                 r_err_overlap;
   logic                 r_err_index;

   logic                 w_start_ok;
   logic                 w_pos_fire;
   logic                 w_edge_fire;
   logic                 w_pos_idx_bad;
   logic                 w_pos_unplaced;
   logic                 w_pos_in_range;
   logic [CELL_W-1:0]    w_cell;
   logic [AW-1:0]        w_addr_a;
   logic [AW-1:0]        w_addr_b;
   logic                 w_edge_idx_bad;
   logic [CW-1:0]        w_xa, w_ya, w_xb, w_yb;
   logic                 w_edge_unplaced;
   logic                 w_edge_ok;
   logic [CW-1:0]        w_diff_x, w_diff_y;
   logic [CW-1:0]        w_dx, w_dy;
   logic [CW-1:0]        w_len;
   logic [CW-1:0]        w_contrib;

   // ------------------------------------------------------------------------
   // Handshake qualifiers. Ready depends only on state, so the fire terms are
   // built from state directly to keep valid out of any ready path.
   // ------------------------------------------------------------------------
   assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_pos_fire  = bus.pos_valid  && (r_state == S_LOAD);
   assign w_edge_fire = bus.edge_valid && (r_state == S_EVAL);

   // ------------------------------------------------------------------------
   // Position beat classification
   // ------------------------------------------------------------------------
   assign w_pos_idx_bad  = (bus.pos_node >= IW'(N_NODE));
   assign w_pos_unplaced = (bus.pos_x == c_UNPLACED) && (bus.pos_y == c_UNPLACED);
   // Sign bit clear plus unsigned compare gives 0 <= coord < N.
   assign w_pos_in_range = !bus.pos_x[CW-1] && (bus.pos_x < CW'(N)) &&
                           !bus.pos_y[CW-1] && (bus.pos_y < CW'(N));
   // Only meaningful when in range; the low bits then hold the full coordinate.
   assign w_cell = bus.pos_x[CELL_W-1:0] * CELL_W'(N) + bus.pos_y[CELL_W-1:0];

   // ------------------------------------------------------------------------
   // Edge evaluation: combinational memory read, registered accumulate
   // ------------------------------------------------------------------------
   assign w_edge_idx_bad = (bus.edge_a >= IW'(N_NODE)) || (bus.edge_b >= IW'(N_NODE));
   assign w_addr_a       = bus.edge_a[AW-1:0];
   assign w_addr_b       = bus.edge_b[AW-1:0];
   assign w_xa           = r_mem_x[w_addr_a];
   assign w_ya           = r_mem_y[w_addr_a];
   assign w_xb           = r_mem_x[w_addr_b];
   assign w_yb           = r_mem_y[w_addr_b];

   assign w_edge_unplaced = ((w_xa == c_UNPLACED) && (w_ya == c_UNPLACED)) ||
                            ((w_xb == c_UNPLACED) && (w_yb == c_UNPLACED));
   assign w_edge_ok       = !w_edge_idx_bad && !w_edge_unplaced;

   assign w_diff_x  = w_xa - w_xb;
   assign w_diff_y  = w_ya - w_yb;
   assign w_dx      = w_diff_x[CW-1] ? (~w_diff_x + CW'(1)) : w_diff_x;
   assign w_dy      = w_diff_y[CW-1] ? (~w_diff_y + CW'(1)) : w_diff_y;
   assign w_len     = w_dx + w_dy;
   // Adjacent cells cost nothing: one unit of length is free.
   assign w_contrib = (w_len != '0) ? (w_len - CW'(1)) : '0;

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and stream ready outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next   = r_state;
      bus.pos_ready  = 1'b0;
      bus.edge_ready = 1'b0;
      busy           = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_LOAD;
         end
         S_LOAD: begin
            bus.pos_ready = 1'b1;
            busy          = 1'b1;
            if (w_pos_fire && (r_pos_cnt == CNT_W'(N_NODE - 1)))
               w_state_next = S_EVAL;
         end
         S_EVAL: begin
            bus.edge_ready = 1'b1;
            busy           = 1'b1;
            if (w_edge_fire && bus.edge_last)
               w_state_next = S_DONE;
         end
         S_DONE: begin
            if (start) w_state_next = S_LOAD;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Position memory. No reset: every run marks all entries unplaced first.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_start_ok) begin
         for (int i = 0; i < N_NODE; i++) begin
            r_mem_x[i] <= c_UNPLACED;
            r_mem_y[i] <= c_UNPLACED;
         end
      end else if (w_pos_fire && !w_pos_idx_bad) begin
         r_mem_x[bus.pos_node[AW-1:0]] <= bus.pos_x;
         r_mem_y[bus.pos_node[AW-1:0]] <= bus.pos_y;
      end
   end

   // ------------------------------------------------------------------------
   // Results, occupancy bitmap and sticky error flags
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_occ          <= '0;
         r_pos_cnt      <= '0;
         r_sum          <= '0;
         r_edge_count   <= '0;
         r_done         <= 1'b0;
         r_err_unplaced <= 1'b0;
         r_err_range    <= 1'b0;
         r_err_overlap  <= 1'b0;
         r_err_index    <= 1'b0;
      end else begin
         r_done <= w_edge_fire && bus.edge_last;

         if (w_start_ok) begin
            r_occ          <= '0;
            r_pos_cnt      <= '0;
            r_sum          <= '0;
            r_edge_count   <= '0;
            r_err_unplaced <= 1'b0;
            r_err_range    <= 1'b0;
            r_err_overlap  <= 1'b0;
            r_err_index    <= 1'b0;
         end

         if (w_pos_fire) begin
            r_pos_cnt <= r_pos_cnt + CNT_W'(1);
            if (w_pos_idx_bad) begin
               r_err_index <= 1'b1;
            end else if (!w_pos_unplaced) begin
               if (!w_pos_in_range) begin
                  r_err_range <= 1'b1;
               end else if (r_occ[w_cell]) begin
                  r_err_overlap <= 1'b1;
               end else begin
                  r_occ[w_cell] <= 1'b1;
               end
            end
         end

         if (w_edge_fire) begin
            r_edge_count <= r_edge_count + CW'(1);
            if (w_edge_idx_bad) begin
               r_err_index <= 1'b1;
            end else if (w_edge_unplaced) begin
               r_err_unplaced <= 1'b1;
            end else begin
               r_sum <= r_sum + w_contrib;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Optional longest-edge tracker
   // ------------------------------------------------------------------------
`ifdef PLACEMENT_COST_MAX_LEN_EN
   logic [CW-1:0] r_max_len;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_max_len <= '0;
      end else if (w_start_ok) begin
         r_max_len <= '0;
      end else if (w_edge_fire && w_edge_ok && (w_len > r_max_len)) begin
         r_max_len <= w_len;
      end
   end

   assign max_len = r_max_len;
`else
   assign max_len = '0;
`endif

   assign done         = r_done;
   assign sum          = r_sum;
   assign edge_count   = r_edge_count;
   assign err_unplaced = r_err_unplaced;
   assign err_range    = r_err_range;
   assign err_overlap  = r_err_overlap;
   assign err_index    = r_err_index;

endmodule
`default_nettype wire
